fifo_sync_ctrl: RTL and testbench

- Parametrised single-clock FIFO. Combines the storage array with pointer and flag control, so users no longer supply pointers or full/empty.
- Adds occupancy count, almost-full/almost-empty thresholds, a registered read port, synchronous flush and sticky overflow/underflow flags.
- Sits between a producer and a consumer in the same clock domain; this is the standard buffering block for UART/SPI datapaths.

---
 rtl/fifo_sync_ctrl.sv | 95 +++++++++
 tb/tb_fifo_sync_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO with pointer/flag control, occupancy, thresholds and sticky errors.
// Define FIFO_FWFT_EN for first-word fall-through reads; default is a registered read port.
module fifo_sync_ctrl #(
  parameter int WIDTH               = 8,
  parameter int DEPTH               = 16,
  parameter int ALMOST_FULL_THRESH  = DEPTH - 2,
  parameter int ALMOST_EMPTY_THRESH = 2,
  localparam int ADDR_WIDTH         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_in,
  input  logic                  write_in,
  input  logic [WIDTH-1:0]      data_write_in,
  input  logic                  read_in,
  output logic [WIDTH-1:0]      data_read_out,
  output logic                  read_valid_out,
  output logic                  full_out,
  output logic                  empty_out,
  output logic                  almost_full_out,
  output logic                  almost_empty_out,
  output logic [ADDR_WIDTH:0]   count_out,
  output logic                  overflow_out,
  output logic                  underflow_out
);

  localparam logic [ADDR_WIDTH:0] AF_TH = (ADDR_WIDTH+1)'(ALMOST_FULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_TH = (ADDR_WIDTH+1)'(ALMOST_EMPTY_THRESH);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic                overflow_q;
  logic                underflow_q;
  logic                flush;
  logic                wr_en;
  logic                rd_en;

  assign flush = !rst_n || clear_in;
  assign wr_en = write_in && !full_out;
  assign rd_en = read_in && !empty_out;

  // Flags derive from the registered pointers only, so they move on the pointer edge.
  assign empty_out        = (wr_ptr == rd_ptr);
  assign full_out         = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                            (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign count_out        = wr_ptr - rd_ptr;
  assign almost_full_out  = (count_out >= AF_TH);
  assign almost_empty_out = (count_out <= AE_TH);
  assign overflow_out     = overflow_q;
  assign underflow_out    = underflow_q;

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (write_in && full_out) overflow_q  <= 1'b1;
      if (read_in && empty_out) underflow_q <= 1'b1;
    end
  end

  // Storage: not reset; a flushing cycle discards its write.
  always_ff @(posedge clk) begin
    if (!flush && wr_en) mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_write_in;
  end

`ifdef FIFO_FWFT_EN
  // Head entry falls through; gated to zero while empty so reset/flush present 0.
  assign data_read_out  = empty_out ? '0 : mem[rd_ptr[ADDR_WIDTH-1:0]];
  assign read_valid_out = !empty_out;
`else
  logic [WIDTH-1:0] rd_data_p1;
  logic             vld_p1;

  // Read stage p1: popped word registered on the accepting edge.
  always_ff @(posedge clk) begin
    if (flush) begin
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= rd_en;
      if (rd_en) rd_data_p1 <= mem[rd_ptr[ADDR_WIDTH-1:0]];
    end
  end

  assign data_read_out  = rd_data_p1;
  assign read_valid_out = vld_p1;
`endif

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Directed self-checking bench for fifo_sync_ctrl (WIDTH=8, DEPTH=16).
module tb_fifo_sync_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear_in;
  logic       write_in;
  logic [7:0] data_write_in;
  logic       read_in;
  logic [7:0] data_read_out;
  logic       read_valid_out;
  logic       full_out;
  logic       empty_out;
  logic       almost_full_out;
  logic       almost_empty_out;
  logic [4:0] count_out;
  logic       overflow_out;
  logic       underflow_out;

  int errors = 0;
  int checks = 0;

  fifo_sync_ctrl #(
    .WIDTH(8), .DEPTH(16), .ALMOST_FULL_THRESH(14), .ALMOST_EMPTY_THRESH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear_in(clear_in),
    .write_in(write_in), .data_write_in(data_write_in), .read_in(read_in),
    .data_read_out(data_read_out), .read_valid_out(read_valid_out),
    .full_out(full_out), .empty_out(empty_out),
    .almost_full_out(almost_full_out), .almost_empty_out(almost_empty_out),
    .count_out(count_out), .overflow_out(overflow_out), .underflow_out(underflow_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clear_in = 1'b0; write_in = 1'b0; read_in = 1'b0; data_write_in = 8'h00;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_empty",    32'(empty_out), 32'd1);
    chk("rst_aempty",   32'(almost_empty_out), 32'd1);
    chk("rst_full",     32'(full_out), 32'd0);
    chk("rst_afull",    32'(almost_full_out), 32'd0);
    chk("rst_count",    32'(count_out), 32'd0);
    chk("rst_dout",     32'(data_read_out), 32'd0);
    chk("rst_vld",      32'(read_valid_out), 32'd0);
    chk("rst_ovf",      32'(overflow_out), 32'd0);
    chk("rst_unf",      32'(underflow_out), 32'd0);

`ifndef FIFO_FWFT_EN
    // Fill 0x00..0x0F.
    for (int i = 0; i < 16; i++) begin
      write_in = 1'b1; data_write_in = 8'(i);
      tick();
      chk("fill_count",  32'(count_out), 32'(i + 1));
      chk("fill_aempty", 32'(almost_empty_out), 32'((i + 1) <= 2));
      chk("fill_afull",  32'(almost_full_out), 32'((i + 1) >= 14));
      chk("fill_full",   32'(full_out), 32'((i + 1) == 16));
      chk("fill_empty",  32'(empty_out), 32'd0);
    end
    data_write_in = 8'hAA;
    tick();
    write_in = 1'b0;
    chk("ovf_flag",  32'(overflow_out), 32'd1);
    chk("ovf_count", 32'(count_out), 32'd16);
    chk("ovf_full",  32'(full_out), 32'd1);

    // Drain in order; 0xAA must never appear.
    for (int i = 0; i < 16; i++) begin
      read_in = 1'b1;
      tick();
      chk("drain_dout",  32'(data_read_out), 32'(i));
      chk("drain_vld",   32'(read_valid_out), 32'd1);
      chk("drain_count", 32'(count_out), 32'(15 - i));
    end
    read_in = 1'b0;
    tick();
    chk("drain_vld_off", 32'(read_valid_out), 32'd0);
    chk("drain_hold",    32'(data_read_out), 32'h0F);
    chk("drain_empty",   32'(empty_out), 32'd1);
    chk("ovf_sticky",    32'(overflow_out), 32'd1);
    read_in = 1'b1;
    tick();
    read_in = 1'b0;
    chk("unf_flag",  32'(underflow_out), 32'd1);
    chk("unf_vld",   32'(read_valid_out), 32'd0);
    chk("unf_count", 32'(count_out), 32'd0);

    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    chk("clr_ovf", 32'(overflow_out), 32'd0);
    chk("clr_unf", 32'(underflow_out), 32'd0);

    // Wrap: 4 bursts of 10 words, reads lag writes by 5 cycles (40 words cross the 32-wrap).
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 15; c++) begin
        write_in = (c < 10);
        data_write_in = 8'(r * 10 + c);
        read_in = (c >= 5);
        tick();
        if (c < 5)       chk("wrap_count", 32'(count_out), 32'(c + 1));
        else if (c < 10) chk("wrap_count", 32'(count_out), 32'd5);
        else             chk("wrap_count", 32'(count_out), 32'(14 - c));
        if (c >= 5) begin
          chk("wrap_dout", 32'(data_read_out), 32'(r * 10 + c - 5));
          chk("wrap_vld",  32'(read_valid_out), 32'd1);
        end
      end
    end
    write_in = 1'b0; read_in = 1'b0;
    tick();
    chk("wrap_empty", 32'(empty_out), 32'd1);
    chk("wrap_ovf",   32'(overflow_out), 32'd0);
    chk("wrap_unf",   32'(underflow_out), 32'd0);

    // Clear with a concurrent write.
    for (int i = 0; i < 5; i++) begin
      write_in = 1'b1; data_write_in = 8'(8'h60 + i);
      tick();
    end
    chk("pre_clr_count", 32'(count_out), 32'd5);
    clear_in = 1'b1; data_write_in = 8'hEE;
    tick();
    clear_in = 1'b0; write_in = 1'b0;
    chk("clr_count", 32'(count_out), 32'd0);
    chk("clr_empty", 32'(empty_out), 32'd1);
    chk("clr_ovf2",  32'(overflow_out), 32'd0);
    chk("clr_unf2",  32'(underflow_out), 32'd0);
    chk("clr_dout",  32'(data_read_out), 32'd0);
    read_in = 1'b1;
    tick();
    read_in = 1'b0;
    chk("clr_discard_unf", 32'(underflow_out), 32'd1);
    chk("clr_discard_vld", 32'(read_valid_out), 32'd0);
    write_in = 1'b1; data_write_in = 8'h77;
    tick();
    write_in = 1'b0; read_in = 1'b1;
    tick();
    read_in = 1'b0;
    chk("post_clr_dout",  32'(data_read_out), 32'h77);
    chk("post_clr_count", 32'(count_out), 32'd0);
`else
    write_in = 1'b1; data_write_in = 8'h5A;
    tick();
    write_in = 1'b0;
    chk("fwft_dout",  32'(data_read_out), 32'h5A);
    chk("fwft_vld",   32'(read_valid_out), 32'd1);
    chk("fwft_count", 32'(count_out), 32'd1);
    read_in = 1'b1;
    tick();
    read_in = 1'b0;
    chk("fwft_pop_empty", 32'(empty_out), 32'd1);
    chk("fwft_pop_vld",   32'(read_valid_out), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      write_in = 1'b1; data_write_in = 8'(i);
      tick();
    end
    write_in = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      chk("fwft_head", 32'(data_read_out), 32'(i));
      chk("fwft_hvld", 32'(read_valid_out), 32'd1);
      read_in = 1'b1;
      tick();
      read_in = 1'b0;
    end
    chk("fwft_end_empty", 32'(empty_out), 32'd1);
    chk("fwft_end_unf",   32'(underflow_out), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
